// File: rtl/fp_convert_unit.sv
// Multi-cycle FP32 <-> int32 conversion unit (FCVT.W.S / WU.S / S.W / S.WU) with a 1-bit/cycle shifter.
// Optional round-to-nearest-even through an extra ROUND state when FCVT_RNE_EN is defined (default: RTZ).
module fp_convert_unit #(
    parameter int unsigned BIAS      = 127,
    parameter int unsigned MAX_SHIFT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_nv,
    output logic        flag_nx
);
    localparam int unsigned CW  = 5;
    localparam logic [8:0]  E0  = 9'(BIAS);
    localparam logic [8:0]  E23 = 9'(BIAS + 23);
    localparam logic [8:0]  E31 = 9'(BIAS + 31);
    localparam logic [8:0]  E32 = 9'(BIAS + 32);
    localparam logic [7:0]  I2F_EXP = 8'(BIAS + 31);

`ifdef FCVT_RNE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_ROUND, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_DONE} state_t;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        nv;
        logic        nx;
    } fin_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mag_q, mag_d;
    logic          g_q, g_d, s_q, s_d;
    logic          left_q, left_d;
    logic          i2f_q, i2f_d;
    logic          wsig_q, wsig_d;
    logic          sgn_q, sgn_d;
    logic [7:0]    exp_q, exp_d;
    logic [31:0]   result_q, result_d;
    logic          nv_q, nv_d, nx_q, nx_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [31:0]   i2f_mag;
    logic [5:0]    clz;
    logic [8:0]    exp_w, k9;
    logic          special;
    logic [31:0]   sh_mag;
    logic          sh_g, sh_s;
    fin_t          fin;

    // Rounding (RNE when enabled) plus saturation and packing of the aligned magnitude.
    function automatic fin_t finalize(input logic i2f, input logic wsig, input logic sgn,
                                      input logic [7:0] fexp, input logic [31:0] mag,
                                      input logic g, input logic s);
        fin_t        f;
        logic        inc;
        logic [32:0] sum;
        logic [24:0] sig;
        f   = '0;
        inc = 1'b0;
        sum = '0;
        sig = '0;
        if (i2f) begin
`ifdef FCVT_RNE_EN
            inc = mag[7] & ((|mag[6:0]) | mag[8]);
`endif
            sig   = {2'b01, mag[30:8]} + 25'(inc);
            f.res = {sgn, fexp + 8'(sig[24]), sig[22:0]};
            f.nx  = |mag[7:0];
        end else begin
`ifdef FCVT_RNE_EN
            inc = g & (s | mag[0]);
`endif
            sum  = {1'b0, mag} + 33'(inc);
            f.nx = g | s;
            if (!wsig) begin
                if (sum[32]) begin
                    f.res = 32'hFFFF_FFFF; f.nv = 1'b1; f.nx = 1'b0;
                end else begin
                    f.res = sum[31:0];
                end
            end else if (!sgn) begin
                if (sum > 33'h0_7FFF_FFFF) begin
                    f.res = 32'h7FFF_FFFF; f.nv = 1'b1; f.nx = 1'b0;
                end else begin
                    f.res = sum[31:0];
                end
            end else begin
                if (sum > 33'h0_8000_0000) begin
                    f.res = 32'h8000_0000; f.nv = 1'b1; f.nx = 1'b0;
                end else begin
                    f.res = -sum[31:0];
                end
            end
        end
        return f;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            left_q      <= 1'b0;
            i2f_q       <= 1'b0;
            wsig_q      <= 1'b0;
            sgn_q       <= 1'b0;
            exp_q       <= '0;
            result_q    <= '0;
            nv_q        <= 1'b0;
            nx_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            g_q         <= g_d;
            s_q         <= s_d;
            left_q      <= left_d;
            i2f_q       <= i2f_d;
            wsig_q      <= wsig_d;
            sgn_q       <= sgn_d;
            exp_q       <= exp_d;
            result_q    <= result_d;
            nv_q        <= nv_d;
            nx_q        <= nx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        g_d      = g_q;
        s_d      = s_q;
        left_d   = left_q;
        i2f_d    = i2f_q;
        wsig_d   = wsig_q;
        sgn_d    = sgn_q;
        exp_d    = exp_q;
        result_d = result_q;
        nv_d     = nv_q;
        nx_d     = nx_q;
        fin      = '0;
        special  = 1'b0;
        k9       = '0;
        exp_w    = {1'b0, operand[30:23]};

        i2f_mag = (!op[0] && operand[31]) ? -operand : operand;
        clz     = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i2f_mag[i]) clz = 6'(31 - i);
        end

        // One alignment step; right shifts feed guard, guard feeds sticky.
        sh_mag = left_q ? (mag_q << 1) : (mag_q >> 1);
        sh_g   = left_q ? g_q : mag_q[0];
        sh_s   = left_q ? s_q : (s_q | g_q);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    i2f_d    = op[1];
                    wsig_d   = ~op[0];
                    g_d      = 1'b0;
                    s_d      = 1'b0;
                    nv_d     = 1'b0;
                    nx_d     = 1'b0;
                    result_d = '0;
                    if (op[1]) begin
                        sgn_d   = ~op[0] & operand[31];
                        mag_d   = i2f_mag;
                        left_d  = 1'b1;
                        exp_d   = I2F_EXP - 8'(clz);
                        k9      = 9'(clz);
                        special = (operand == 32'h0);
                    end else begin
                        sgn_d   = operand[31];
                        mag_d   = {8'h00, 1'b1, operand[22:0]};
                        exp_d   = operand[30:23];
                        left_d  = (exp_w >= E23);
                        k9      = (exp_w >= E23) ? (exp_w - E23) : (E23 - exp_w);
                        special = 1'b1;
                        if (operand[30:23] == 8'hFF && operand[22:0] != 23'h0) begin
                            result_d = op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
                            nv_d     = 1'b1;
                        end else if (exp_w < E0) begin
                            nx_d = |operand[30:0];
                        end else if (!op[0] && exp_w >= E31) begin
                            result_d = operand[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                            nv_d     = (operand != 32'hCF00_0000);
                        end else if (op[0] && !operand[31] && exp_w >= E32) begin
                            result_d = 32'hFFFF_FFFF;
                            nv_d     = 1'b1;
                        end else if (op[0] && operand[31]) begin
                            nv_d = 1'b1;
                        end else begin
                            special = 1'b0;
                        end
                    end
                    cnt_d = (k9 > 9'(MAX_SHIFT)) ? CW'(MAX_SHIFT) : CW'(k9);
                    if (special) begin
                        state_d = ST_DONE;
                    end else if (cnt_d != '0) begin
                        state_d = ST_ALIGN;
                    end else begin
`ifdef FCVT_RNE_EN
                        state_d = ST_ROUND;
`else
                        fin      = finalize(op[1], ~op[0], sgn_d, exp_d, mag_d, 1'b0, 1'b0);
                        result_d = fin.res;
                        nv_d     = fin.nv;
                        nx_d     = fin.nx;
                        state_d  = ST_DONE;
`endif
                    end
                end
            end
            ST_ALIGN: begin
                mag_d = sh_mag;
                g_d   = sh_g;
                s_d   = sh_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef FCVT_RNE_EN
                    state_d = ST_ROUND;
`else
                    fin      = finalize(i2f_q, wsig_q, sgn_q, exp_q, sh_mag, sh_g, sh_s);
                    result_d = fin.res;
                    nv_d     = fin.nv;
                    nx_d     = fin.nx;
                    state_d  = ST_DONE;
`endif
                end
            end
`ifdef FCVT_RNE_EN
            ST_ROUND: begin
                fin      = finalize(i2f_q, wsig_q, sgn_q, exp_q, mag_q, g_q, s_q);
                result_d = fin.res;
                nv_d     = fin.nv;
                nx_d     = fin.nx;
                state_d  = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_nv   = nv_q;
    assign flag_nx   = nx_q;

endmodule
